// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: issues fetches on a req/addr_ok/data_ok SRAM-like bus and buffers
// the returned instructions in order for ID. Handles redirect flush and misaligned-PC ADEF.
module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          FQ_DEPTH = 4,
    parameter int          CNT_W    = $clog2(FQ_DEPTH) + 1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        inst_req,
    output logic        inst_wr,
    output logic [1:0]  inst_size,
    output logic [31:0] inst_addr,
    output logic [31:0] inst_wdata,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    input  logic        id_allow_in,
    output logic        if_id_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_adef,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int             PTR_W   = $clog2(FQ_DEPTH);
    localparam logic [CNT_W:0] DEPTH_L = FQ_DEPTH[CNT_W:0];

    // Handshakes: a bus request transfers on inst_req & inst_addr_ok, and once raised
    // inst_req/inst_addr hold until that transfer; an ID transfer is if_id_valid & id_allow_in.

    logic [31:0]        fetch_pc;
    logic [31:0]        q_pc   [FQ_DEPTH];
    logic [31:0]        q_inst [FQ_DEPTH];
    logic [FQ_DEPTH-1:0] q_adef;
    logic [FQ_DEPTH-1:0] q_filled;
    logic [PTR_W-1:0]   head_ptr;
    logic [PTR_W-1:0]   alloc_ptr;
    logic [PTR_W-1:0]   fill_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   discard_cnt;
    logic [CNT_W-1:0]   pend_cnt;
    logic               req_hold;
    logic               hold_stale;
    logic [31:0]        hold_addr;
    logic               adef_stall;
    logic               rst_dly;

    logic [CNT_W:0]     occupancy;
    logic               has_space;
    logic               pc_aligned;
    logic               can_start;
    logic               fresh_issue;
    logic               hs;
    logic               hs_stale;
    logic               alloc_bus;
    logic               adef_alloc;
    logic               drop_data;
    logic               fill_data;
    logic               pop;
    logic [CNT_W-1:0]   count_nxt;
    logic [CNT_W-1:0]   discard_nxt;
    logic [CNT_W-1:0]   pend_nxt;

    assign inst_wr    = 1'b0;
    assign inst_size  = 2'b10;
    assign inst_wdata = 32'h0;

    // Discarded-but-outstanding responses still occupy a slot so a late response never overflows.
    assign occupancy  = {1'b0, count} + {1'b0, discard_cnt};
    assign has_space  = occupancy < DEPTH_L;
    assign pc_aligned = (fetch_pc[1:0] == 2'b00);
    assign can_start  = !rst && !rst_dly && !redirect_valid && !adef_stall && !req_hold && has_space;

    assign fresh_issue = can_start && pc_aligned;
    assign adef_alloc  = can_start && !pc_aligned;

    assign inst_req  = !rst && (req_hold || fresh_issue);
    assign inst_addr = req_hold ? hold_addr : fetch_pc;

    assign hs        = inst_req && inst_addr_ok;
    assign hs_stale  = hs && req_hold && hold_stale;
    assign alloc_bus = hs && !hs_stale && !redirect_valid;

    assign drop_data = inst_data_ok && (discard_cnt != '0);
    assign fill_data = inst_data_ok && (discard_cnt == '0);

    assign if_id_valid = !rst && (count != '0) && q_filled[head_ptr] && !redirect_valid;
    assign pop         = if_id_valid && id_allow_in;
    assign if_inst     = q_inst[head_ptr];
    assign if_pc       = q_pc[head_ptr];
    assign if_adef     = q_adef[head_ptr];

    always_comb begin
        count_nxt   = count;
        discard_nxt = discard_cnt;
        pend_nxt    = pend_cnt;
        if (redirect_valid) begin
            // Every unfilled entry and any request accepted right now becomes a response to drop.
            count_nxt   = '0;
            pend_nxt    = '0;
            discard_nxt = discard_cnt + pend_cnt + CNT_W'(hs) - CNT_W'(fill_data);
        end else begin
            count_nxt   = count + CNT_W'(alloc_bus || adef_alloc) - CNT_W'(pop);
            pend_nxt    = pend_cnt + CNT_W'(alloc_bus) - CNT_W'(fill_data);
            discard_nxt = discard_cnt + CNT_W'(hs_stale);
        end
        discard_nxt = discard_nxt - CNT_W'(drop_data);
    end

    always_ff @(posedge clk) begin
        rst_dly <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            head_ptr    <= '0;
            alloc_ptr   <= '0;
            fill_ptr    <= '0;
            count       <= '0;
            discard_cnt <= '0;
            pend_cnt    <= '0;
            adef_stall  <= 1'b0;
        end else begin
            count       <= count_nxt;
            discard_cnt <= discard_nxt;
            pend_cnt    <= pend_nxt;
            if (redirect_valid) begin
                fetch_pc   <= redirect_pc;
                head_ptr   <= '0;
                alloc_ptr  <= '0;
                fill_ptr   <= '0;
                adef_stall <= 1'b0;
            end else begin
                if (alloc_bus) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (alloc_bus || adef_alloc) begin
                    alloc_ptr <= alloc_ptr + PTR_W'(1);
                end
                if (adef_alloc) begin
                    adef_stall <= 1'b1;
                end
                if (fill_data) begin
                    fill_ptr <= fill_ptr + PTR_W'(1);
                end
                if (pop) begin
                    head_ptr <= head_ptr + PTR_W'(1);
                end
            end
        end
    end

    // A request that misses addr_ok is frozen; a redirect while frozen only marks it stale.
    always_ff @(posedge clk) begin
        if (rst) begin
            req_hold   <= 1'b0;
            hold_stale <= 1'b0;
            hold_addr  <= 32'h0;
        end else if (inst_req && !inst_addr_ok) begin
            req_hold   <= 1'b1;
            hold_stale <= (req_hold && hold_stale) || redirect_valid;
            hold_addr  <= inst_addr;
        end else begin
            req_hold   <= 1'b0;
            hold_stale <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q_filled <= '0;
            q_adef   <= '0;
        end else if (!redirect_valid) begin
            if (alloc_bus) begin
                q_filled[alloc_ptr] <= 1'b0;
                q_adef[alloc_ptr]   <= 1'b0;
            end
            if (adef_alloc) begin
                q_filled[alloc_ptr] <= 1'b1;
                q_adef[alloc_ptr]   <= 1'b1;
            end
            if (fill_data) begin
                q_filled[fill_ptr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid) begin
            if (alloc_bus) begin
                q_pc[alloc_ptr] <= inst_addr;
            end
            if (adef_alloc) begin
                q_pc[alloc_ptr]   <= fetch_pc;
                q_inst[alloc_ptr] <= 32'h0;
            end
            if (fill_data) begin
                q_inst[fill_ptr] <= inst_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && inst_data_ok) begin
            assert (pend_cnt != '0 || discard_cnt != '0)
            else $error("if_fetch_queue: data_ok with no outstanding request");
        end
    end

endmodule

// File: doc/if_fetch_queue.md
Name: if_fetch_queue

Overview:
- Next-generation instruction-fetch stage for the LoongArch pipeline.
- Drives a request/response SRAM-like instruction bus (req/addr_ok/data_ok) with up to FQ_DEPTH requests in flight.
- Holds returned instructions in an in-order fetch queue and hands them to ID through valid/allow_in.
- Supports redirect (branch/exception) with flush, discard of stale in-flight responses, and ADEF on misaligned PC.

Parameters:
- RESET_PC, 32'h1c000000: first PC fetched after reset.
- FQ_DEPTH, 4: fetch-queue entries; power of 2, min 2. Also bounds requests in flight.
- CNT_W, $clog2(FQ_DEPTH)+1: width of occupancy and discard counters.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- inst_req  out  1  bus request.
- inst_wr  out  1  tied 0.
- inst_size  out  2  tied 2'b10.
- inst_addr  out  32  request address.
- inst_wdata  out  32  tied 0.
- inst_addr_ok  in  1  request accepted this cycle (handshake = inst_req & inst_addr_ok).
- inst_data_ok  in  1  response valid; responses return in request order.
- inst_rdata  in  32  response instruction.
- id_allow_in  in  1  ID accepts an entry this cycle.
- if_id_valid  out  1  head entry valid to ID.
- if_inst  out  32  head instruction.
- if_pc  out  32  head PC.
- if_adef  out  1  head entry carries an ADEF exception.
- redirect_valid  in  1  flush and refetch (taken branch, exception, ertn).
- redirect_pc  in  32  new fetch PC.

Behaviour:
- State:
  - fetch_pc.
  - Queue of FQ_DEPTH entries {pc, inst, adef, filled}, with head/alloc/fill pointers and count.
  - discard_cnt.
  - req_hold plus held address and held stale flag.
  - adef_stall.
- Reset values:
  - fetch_pc=RESET_PC; count=0; all pointers=0; discard_cnt=0; req_hold=0; adef_stall=0.
  - inst_req=0 and if_id_valid=0 during and one cycle after reset deassertion; other outputs are don't-care while invalid.
- Issue condition: inst_req=1 when req_hold, or when all of the following hold:
  - !rst, !redirect_valid, !adef_stall;
  - fetch_pc[1:0]==0;
  - count+discard_cnt<FQ_DEPTH.
- inst_addr: held address when req_hold, else fetch_pc.
- Protocol rule: once inst_req rises, inst_req and inst_addr stay stable until inst_addr_ok. If there is no handshake, latch req_hold=1 with the address.
- On handshake:
  - Fresh request: allocate an entry at alloc_ptr {pc=addr, filled=0, adef=0}; count+1; fetch_pc+=4.
  - Held request whose stale flag is set: no allocation; discard_cnt+1.
  - req_hold clears.
- On data_ok:
  - If discard_cnt>0: decrement and drop the data.
  - Else: write inst_rdata into the entry at fill_ptr, set filled=1, advance fill_ptr.
  - data_ok with no outstanding request is illegal; assert in simulation.
- Misaligned fetch_pc (bits[1:0]!=0) with space available and no req_hold:
  - Allocate an entry {pc=fetch_pc, inst=0, adef=1, filled=1}; issue no bus request.
  - Set adef_stall=1; the stall persists until redirect.
- Output to ID: if_id_valid = count>0 & head.filled & !redirect_valid. A pop happens on if_id_valid & id_allow_in: head+1, count-1.
- Latency: handshake in cycle t with data_ok in t+1 gives if_id_valid in t+2. Sustained throughput is 1 instruction/cycle when the bus returns 1/cycle and ID never stalls.
- Redirect (registered, takes effect next cycle):
  - fetch_pc=redirect_pc; queue cleared (count=0, pointers realigned); adef_stall=0.
  - discard_cnt += number of allocated unfilled entries, excluding any entry filled by a same-cycle data_ok.
  - Same-cycle handshake: the accepted request is also counted into discard_cnt.
  - Pending req_hold: keep the request, set the stale flag, count it on its handshake.
  - Redirect beats a same-cycle pop and a same-cycle allocation.
  - Back-to-back redirects: the last target wins and discard counts accumulate.
- Full queue: no new requests; in-flight responses always have a reserved slot, so no overflow is possible.
- rst mid-operation: all state returns to reset values. The bus is assumed reset concurrently, so pending responses are not tracked.

Test Plan:
- Reset then ID always ready with 1-cycle bus → addresses 0x1c000000, 0x1c000004, 0x1c000008 …; first if_id_valid 2 cycles after the first handshake; if_pc/if_inst match memory in order.
- id_allow_in=0 for 10 cycles with FQ_DEPTH=4 → exactly 4 handshakes, then inst_req=0; on release, 4 in-order pops and fetch resumes at 0x1c000010.
- Bus with addr_ok immediate and data_ok 3 cycles late, 3 in flight, redirect_pc=0x1c000100 → discard_cnt=3; 3 responses dropped; first instruction to ID has pc 0x1c000100.
- inst_req held with addr_ok=0 when redirect arrives → inst_addr unchanged until addr_ok; that response is discarded; next request is 0x1c000100.
- redirect_pc=0x1c000102 → no bus request; one entry pc=0x1c000102, if_adef=1, inst=0; stall until redirect to 0x1c000200 resumes fetch.
- redirect in the same cycle as data_ok and as a pop → the completing response is not double-counted, the pop is ignored, and the queue is empty the next cycle.
